// File: rtl/pipeline_ctrl_if.sv
// Control bus between the pipeline datapath and the stall/flush sequencer.
// The datapath side is the master; the sequencer is the slave.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_rs1;
  logic [4:0]       IF_ID_rs2;
  logic             IF_ID_use_rs1;
  logic             IF_ID_use_rs2;
  logic             branch;
  logic             branch_taken;
  logic [4:0]       ID_EX_rd;
  logic             ID_EX_mem_read;
  logic [4:0]       EX_MEM_rd;
  logic             EX_MEM_mem_read;
  logic             dmem_valid;
  logic             dmem_ready;

  logic             pc_en;
  logic             IF_ID_en;
  logic             ID_EX_en;
  logic             EX_MEM_en;
  logic             MEM_WB_en;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] freeze_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2, branch, branch_taken,
           ID_EX_rd, ID_EX_mem_read, EX_MEM_rd, EX_MEM_mem_read, dmem_valid, dmem_ready,
    input  pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
           state, stall_cycles, freeze_cycles, flush_count, mem_timeout
  );

  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, IF_ID_use_rs1, IF_ID_use_rs2, branch, branch_taken,
           ID_EX_rd, ID_EX_mem_read, EX_MEM_rd, EX_MEM_mem_read, dmem_valid, dmem_ready,
    output pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush,
           state, stall_cycles, freeze_cycles, flush_count, mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch-operand
// hazards, data-memory freeze FSM with watchdog, and saturating event counters.
module pipeline_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic [WC_W-1:0]        wait_cnt_reg, wait_cnt_next;
  logic                   mem_timeout_reg, mem_timeout_next;

  logic [4:0]             rs [2];
  logic [1:0]             use_rs, m, ex_hit, mem_hit;
  logic                   load_use, br_mem, hz, freeze;
  logic [2:0]             inc;  // {flush, freeze, stall}
  logic [2:0][CNT_W-1:0]  cnt_q;

  assign rs[0]  = bus.IF_ID_rs1;
  assign rs[1]  = bus.IF_ID_rs2;
  assign use_rs = {bus.IF_ID_use_rs2, bus.IF_ID_use_rs1};

  // x0 is never a real dependency, so it is masked out of every match.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign m[gi]       = use_rs[gi] & (rs[gi] != 5'd0);
    assign ex_hit[gi]  = m[gi] & (rs[gi] == bus.ID_EX_rd);
    assign mem_hit[gi] = m[gi] & (rs[gi] == bus.EX_MEM_rd);
  end

  assign load_use = bus.ID_EX_mem_read & (|ex_hit);
  assign br_mem   = bus.branch & bus.EX_MEM_mem_read & (|mem_hit);
  assign hz       = load_use | br_mem;
  assign freeze   = (state_reg == RUN      & bus.dmem_valid & ~bus.dmem_ready) |
                    (state_reg == MEM_WAIT & ~bus.dmem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (bus.dmem_valid & ~bus.dmem_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (bus.dmem_ready)                   state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // The watchdog only observes; the access keeps waiting after a timeout.
  always_comb begin
    wait_cnt_next = '0;
    if (state_reg == MEM_WAIT)
      wait_cnt_next = (wait_cnt_reg == WC_MAX) ? WC_MAX : wait_cnt_reg + WC_W'(1);
    mem_timeout_next = mem_timeout_reg | ((state_reg == MEM_WAIT) & (wait_cnt_next == WC_MAX));
  end

  always_comb begin
    bus.pc_en       = 1'b1;
    bus.IF_ID_en    = 1'b1;
    bus.ID_EX_en    = 1'b1;
    bus.EX_MEM_en   = 1'b1;
    bus.MEM_WB_en   = 1'b1;
    bus.IF_ID_flush = 1'b0;
    bus.ID_EX_flush = 1'b0;
    inc             = 3'b000;
    if (rst) begin
      {bus.pc_en, bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en} = 5'b00000;
      bus.IF_ID_flush = 1'b1;
      bus.ID_EX_flush = 1'b1;
    end else if (freeze) begin
      {bus.pc_en, bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en} = 5'b00000;
      inc[1] = 1'b1;
    end else if (hz) begin
      // Branch operands are stale here, so a taken redirect is dropped.
      bus.pc_en       = 1'b0;
      bus.IF_ID_en    = 1'b0;
      bus.ID_EX_flush = 1'b1;
      inc[0]          = 1'b1;
    end else if (bus.branch_taken & bus.branch) begin
      bus.IF_ID_flush = 1'b1;
      inc[2]          = 1'b1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst)
        cnt_reg <= '0;
      else if (inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
    assign cnt_q[gi] = cnt_reg;
  end

  assign bus.state         = state_reg;
  assign bus.stall_cycles  = cnt_q[0];
  assign bus.freeze_cycles = cnt_q[1];
  assign bus.flush_count   = cnt_q[2];
  assign bus.mem_timeout   = mem_timeout_reg;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: each step pushes its expected outputs to a
// scoreboard queue, which is popped and compared mid-cycle.
module tb_pipeline_ctrl;
  localparam int CNT_W = 16;

  // {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_flush, ID_EX_flush}
  localparam logic [6:0] C_RUN   = 7'b11111_00;
  localparam logic [6:0] C_STALL = 7'b00111_01;
  localparam logic [6:0] C_BRFL  = 7'b11111_10;
  localparam logic [6:0] C_FRZ   = 7'b00000_00;
  localparam logic [6:0] C_RST   = 7'b00000_11;

  typedef struct {
    string      tag;
    logic [6:0] ctrl;
    logic       st;
    int         stall;
    int         frz;
    int         fl;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string f, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, f, obs, exp);
    end
  endtask

  task automatic idle();
    bus.IF_ID_rs1 = 5'd0; bus.IF_ID_rs2 = 5'd0;
    bus.IF_ID_use_rs1 = 1'b0; bus.IF_ID_use_rs2 = 1'b0;
    bus.branch = 1'b0; bus.branch_taken = 1'b0;
    bus.ID_EX_rd = 5'd0; bus.ID_EX_mem_read = 1'b0;
    bus.EX_MEM_rd = 5'd0; bus.EX_MEM_mem_read = 1'b0;
    bus.dmem_valid = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  // Inputs are already driven; push expectations, compare at negedge, advance.
  task automatic step(input string tag, input logic [6:0] ctrl, input logic st,
                      input int stall, input int frz, input int fl, input logic to);
    exp_t e;
    logic [6:0] obs;
    e.tag = tag; e.ctrl = ctrl; e.st = st; e.stall = stall; e.frz = frz; e.fl = fl; e.to = to;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    obs = {bus.pc_en, bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en,
           bus.IF_ID_flush, bus.ID_EX_flush};
    chk(e.tag, "ctrl",   32'(obs), 32'(e.ctrl));
    chk(e.tag, "state",  32'(bus.state), 32'(e.st));
    chk(e.tag, "stall",  32'(bus.stall_cycles), 32'(e.stall));
    chk(e.tag, "freeze", 32'(bus.freeze_cycles), 32'(e.frz));
    chk(e.tag, "flush",  32'(bus.flush_count), 32'(e.fl));
    chk(e.tag, "tmo",    32'(bus.mem_timeout), 32'(e.to));
    $display("step %-10s ctrl=%b state=%0d stall=%0d freeze=%0d flush=%0d tmo=%0d",
             e.tag, obs, bus.state, bus.stall_cycles, bus.freeze_cycles,
             bus.flush_count, bus.mem_timeout);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    step("reset", C_RST, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Load-use: lw x5 in EX, add reading x5 in ID
    idle(); bus.ID_EX_mem_read = 1; bus.ID_EX_rd = 5; bus.IF_ID_rs1 = 5; bus.IF_ID_use_rs1 = 1;
    step("lu_stall", C_STALL, 0, 0, 0, 0, 0);
    idle(); bus.EX_MEM_mem_read = 1; bus.EX_MEM_rd = 5; bus.IF_ID_rs1 = 5; bus.IF_ID_use_rs1 = 1;
    step("lu_after", C_RUN, 0, 1, 0, 0, 0);
    idle(); bus.ID_EX_mem_read = 1; bus.ID_EX_rd = 0; bus.IF_ID_rs1 = 0; bus.IF_ID_use_rs1 = 1;
    step("lu_x0", C_RUN, 0, 1, 0, 0, 0);
    idle(); bus.ID_EX_mem_read = 1; bus.ID_EX_rd = 5; bus.IF_ID_rs1 = 5; bus.IF_ID_use_rs1 = 0;
    step("lu_nouse", C_RUN, 0, 1, 0, 0, 0);
    idle(); bus.ID_EX_mem_read = 1; bus.ID_EX_rd = 9; bus.IF_ID_rs2 = 9; bus.IF_ID_use_rs2 = 1;
    step("lu_rs2", C_STALL, 0, 1, 0, 0, 0);

    // Branch after load: lw x6 in EX, beq x6,x1 in ID; stale taken ignored
    idle(); bus.ID_EX_mem_read = 1; bus.ID_EX_rd = 6; bus.branch = 1; bus.branch_taken = 1;
    bus.IF_ID_rs1 = 6; bus.IF_ID_use_rs1 = 1; bus.IF_ID_rs2 = 1; bus.IF_ID_use_rs2 = 1;
    step("br_ex", C_STALL, 0, 2, 0, 0, 0);
    bus.ID_EX_mem_read = 0; bus.ID_EX_rd = 0; bus.EX_MEM_mem_read = 1; bus.EX_MEM_rd = 6;
    step("br_mem", C_STALL, 0, 3, 0, 0, 0);
    bus.EX_MEM_mem_read = 0; bus.EX_MEM_rd = 0;
    step("br_taken", C_BRFL, 0, 4, 0, 0, 0);
    idle();
    step("br_done", C_RUN, 0, 4, 0, 1, 0);

    // ALU result forwarded to branch compare: no stall
    idle(); bus.ID_EX_rd = 7; bus.branch = 1; bus.IF_ID_rs1 = 7; bus.IF_ID_use_rs1 = 1;
    step("alu_nt", C_RUN, 0, 4, 0, 1, 0);
    bus.branch_taken = 1;
    step("alu_tk", C_BRFL, 0, 4, 0, 1, 0);
    idle(); bus.branch_taken = 1;
    step("tk_nobr", C_RUN, 0, 4, 0, 2, 0);

    // Memory wait for 3 cycles, then ready
    idle(); bus.dmem_valid = 1;
    step("mw_1", C_FRZ, 0, 4, 0, 2, 0);
    step("mw_2", C_FRZ, 1, 4, 1, 2, 0);
    step("mw_3", C_FRZ, 1, 4, 2, 2, 0);
    bus.dmem_ready = 1;
    step("mw_rdy", C_RUN, 1, 4, 3, 2, 0);
    idle(); bus.dmem_valid = 1; bus.dmem_ready = 1;
    step("mw_1cyc", C_RUN, 0, 4, 3, 2, 0);
    idle();
    step("mw_idle", C_RUN, 0, 4, 3, 2, 0);

    // Freeze overlapping a load-use hazard
    idle(); bus.dmem_valid = 1; bus.ID_EX_mem_read = 1; bus.ID_EX_rd = 3;
    bus.IF_ID_rs1 = 3; bus.IF_ID_use_rs1 = 1;
    step("ov_frz1", C_FRZ, 0, 4, 3, 2, 0);
    step("ov_frz2", C_FRZ, 1, 4, 4, 2, 0);
    bus.dmem_ready = 1;
    step("ov_stall", C_STALL, 1, 4, 5, 2, 0);
    idle(); bus.EX_MEM_mem_read = 1; bus.EX_MEM_rd = 3; bus.IF_ID_rs1 = 3; bus.IF_ID_use_rs1 = 1;
    step("ov_after", C_RUN, 0, 5, 5, 2, 0);

    // Watchdog: TIMEOUT = 4, ready low for 6 cycles
    idle(); bus.dmem_valid = 1;
    step("to_1", C_FRZ, 0, 5, 5, 2, 0);
    step("to_2", C_FRZ, 1, 5, 6, 2, 0);
    step("to_3", C_FRZ, 1, 5, 7, 2, 0);
    step("to_4", C_FRZ, 1, 5, 8, 2, 0);
    step("to_5", C_FRZ, 1, 5, 9, 2, 0);
    step("to_6", C_FRZ, 1, 5, 10, 2, 1);
    bus.dmem_ready = 1;
    step("to_rdy", C_RUN, 1, 5, 11, 2, 1);
    idle();
    step("to_hold", C_RUN, 0, 5, 11, 2, 1);

    // Reset asserted while in MEM_WAIT
    idle(); bus.dmem_valid = 1;
    step("rw_1", C_FRZ, 0, 5, 11, 2, 1);
    step("rw_2", C_FRZ, 1, 5, 12, 2, 1);
    rst = 1'b1;
    step("rw_rst1", C_RST, 1, 5, 13, 2, 1);
    step("rw_rst2", C_RST, 0, 0, 0, 0, 0);
    rst = 1'b0; idle();
    step("rw_run", C_RUN, 0, 0, 0, 0, 0);

    n_checks++;
    assert (sb.size() == 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
